serial_subtractor_nbit: RTL and testbench

Bit-serial N-bit subtractor computing `diff = a - b - bin` one bit per clock, LSB first, with a registered borrow chain. It is the inverse arithmetic counterpart of the team's ripple/full-adder blocks. It is intended for area-constrained datapaths and as a sequential exercise of the 1-bit full-subtractor cell. A start/busy/done handshake frames each operation.

---
 rtl/serial_arith_pkg.sv | 21 ++
 rtl/full_subtractor_1bit.sv | 19 +
 rtl/serial_subtractor_nbit.sv | 122 ++++++++++++
 tb/tb_serial_subtractor_nbit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   sub_state_t   : control states of the serial subtractor
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : bit-counter width for a given operand width (minimum 1)
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice;
    // WIDTH=1 still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor: diff = a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   diff      : difference bit
//   bout      : borrow out
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : operation request, sampled only in IDLE
//   a, b, bin      : operands and borrow in, captured on the accepted start edge
//   busy           : high during the SHIFT phase
//   done           : one-cycle pulse when diff/bout are updated
//   diff, bout     : result modulo 2^WIDTH and final borrow out (held)
module serial_subtractor_nbit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             fs_diff;
    logic             fs_bout;

    // Single cell; borrow is fed back through br_q.
    full_subtractor_1bit u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Shift-then-insert keeps this valid for WIDTH=1 as well.
                sr_d            = sr_q >> 1;
                sr_d[WIDTH-1]   = fs_diff;
                sa_d            = sa_q >> 1;
                sb_d            = sb_q >> 1;
                br_d            = fs_bout;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = sr_d;
                    bout_d  = fs_bout;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Decoded straight from the state register, so still free of input paths.
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
module tb_serial_subtractor_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1;
    logic       diff1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_subtractor_nbit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    serial_subtractor_nbit #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_w8: busy=%b done=%b diff=%0d bout=%b, want all 0", busy, done, diff, bout);
        end
        tests_run++;
        if ({busy1, done1, diff1, bout1} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_w1: busy=%b done=%b diff=%b bout=%b, want all 0", busy1, done1, diff1, bout1);
        end
        rst = 1'b0;
        tick();
    endtask

    // Called in IDLE, just after an edge. Returns after the DONE->IDLE edge.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                           input logic [7:0] ed, input logic eb, input string name);
        int cycles;
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta; b = ~tb_v; bin = ~tbin;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_busy: busy=%b, want 1", name, busy);
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles != 8) begin
            tests_failed++;
            $display("FAIL %s_latency: done after %0d cycles, want 8", name, cycles);
        end
        tests_run++;
        if (diff !== ed || bout !== eb) begin
            tests_failed++;
            $display("FAIL %s_result: diff=%0d bout=%b, want diff=%0d bout=%b", name, diff, bout, ed, eb);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: done=%b busy=%b, want 0 0", name, done, busy);
        end
    endtask

    task automatic test_basic();
        run_op8(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, "basic_100_37");
        run_op8(8'd5, 8'd10, 1'b0, 8'd251, 1'b1, "basic_5_10");
    endtask

    task automatic test_boundaries();
        run_op8(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, "bound_0_0_1");
        run_op8(8'd255, 8'd255, 1'b0, 8'd0, 1'b0, "bound_255_255_0");
        run_op8(8'd255, 8'd0, 1'b1, 8'd254, 1'b0, "bound_255_0_1");
    endtask

    task automatic test_ignored_start();
        int done_cnt;
        int done_at;
        logic [7:0] got_diff;
        done_cnt = 0;
        done_at = -1;
        got_diff = '0;
        a = 8'd200; b = 8'd1; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'd9; b = 8'd9;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 3 || k == 8);
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
                got_diff = diff;
            end
        end
        tests_run++;
        if (done_cnt != 1 || done_at != 8) begin
            tests_failed++;
            $display("FAIL ignore_done: %0d pulses, last at cycle %0d, want 1 at cycle 8", done_cnt, done_at);
        end
        tests_run++;
        if (got_diff !== 8'd199) begin
            tests_failed++;
            $display("FAIL ignore_diff: diff=%0d, want 199", got_diff);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            tests_failed++;
            $display("FAIL midreset_out: busy=%b done=%b diff=%0d bout=%b, want all 0", busy, done, diff, bout);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        run_op8(8'd7, 8'd3, 1'b0, 8'd4, 1'b0, "after_reset_7_3");
    endtask

    task automatic test_back_to_back();
        int ndone;
        int last_at;
        int bad_gap;
        int bad_diff;
        logic prev_done;
        ndone = 0; last_at = -1; bad_gap = 0; bad_diff = 0;
        prev_done = 1'b0;
        a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done === 1'b1) begin
                if (prev_done) bad_gap++;
                if (last_at >= 0 && k - last_at != 10) bad_gap++;
                if (diff !== 8'd30 || bout !== 1'b0) bad_diff++;
                last_at = k;
                ndone++;
            end
            prev_done = (done === 1'b1);
        end
        start = 1'b0;
        tests_run++;
        if (ndone != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: %0d completions, want 4", ndone);
        end
        tests_run++;
        if (bad_gap != 0) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d bad gaps, want 0 (period 10)", bad_gap);
        end
        tests_run++;
        if (bad_diff != 0) begin
            tests_failed++;
            $display("FAIL b2b_result: %0d wrong results, want 0 (diff 30)", bad_diff);
        end
        repeat (2) tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_stop: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_width1();
        logic [7:0] exp_d;
        logic [7:0] exp_b;
        logic [2:0] idx;
        int cycles;
        // index = {a, b, bin}
        exp_d = 8'b1001_0110;
        exp_b = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            a1 = idx[2]; b1 = idx[1]; bin1 = idx[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1 = ~idx[2]; b1 = ~idx[1]; bin1 = ~idx[0];
            cycles = 0;
            while (done1 !== 1'b1 && cycles < 10) begin
                tick();
                cycles++;
            end
            tests_run++;
            if (cycles != 1 || diff1 !== exp_d[i] || bout1 !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL w1_abc=%b: cycles=%0d diff=%b bout=%b, want cycles=1 diff=%b bout=%b",
                         idx, cycles, diff1, bout1, exp_d[i], exp_b[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
